// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational multiplier
// between NREQ requesters, with registered operands and a valid/ready result.
//
// state | meaning
// IDLE  | searching for a requester from rr_ptr onwards; grant and capture operands
// ISSUE | operands stable on mul_x/mul_y, multiplier settling
// RESP  | registered product presented on rsp_*, waiting for rsp_ready
module mul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      mul_x,
    output logic [W-1:0]      mul_y,
    input  logic [2*W-1:0]    mul_p,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*W-1:0]    rsp_p,
    output logic [IDW-1:0]    rsp_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] gnt_sel;
    logic           gnt_hit;
    logic           load_op;
    logic           load_rsp;

    // rr_ptr is always below NREQ, so a single subtract keeps the index in range
    // and ids >= NREQ can never be produced for non-power-of-two NREQ.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return IDW'(sum);
    endfunction

    // Walk the offsets from far to near so the nearest valid requester wins.
    always_comb begin
        gnt_hit = 1'b0;
        gnt_sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[rr_index(rr_ptr, k)]) begin
                gnt_hit = 1'b1;
                gnt_sel = rr_index(rr_ptr, k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        load_op   = 1'b0;
        load_rsp  = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_hit) begin
                    req_ready[gnt_sel] = 1'b1;
                    load_op            = 1'b1;
                    state_nxt          = ISSUE;
                end
            end
            ISSUE: begin
                load_rsp  = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rsp_valid = (state == RESP);

    // Operands only change on a grant so the multiplier inputs never toggle idly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            gnt_id <= '0;
            mul_x  <= '0;
            mul_y  <= '0;
            rsp_p  <= '0;
            rsp_id <= '0;
        end else begin
            if (load_op) begin
                mul_x  <= req_x[int'(gnt_sel)*W +: W];
                mul_y  <= req_y[int'(gnt_sel)*W +: W];
                gnt_id <= gnt_sel;
                rr_ptr <= rr_index(gnt_sel, 1);
            end
            if (load_rsp) begin
                rsp_p  <= mul_p;
                rsp_id <= gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: a round-robin reference model predicts
// grants and products, a monitor checks every response the DUT presents.
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      mul_x;
    logic [W-1:0]      mul_y;
    logic [2*W-1:0]    mul_p;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*W-1:0]    rsp_p;
    logic [IDW-1:0]    rsp_id;

    always #5 clk = ~clk;

    assign mul_p = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};

    mul_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id)
    );

    // Second instance with a non-power-of-two requester count.
    logic          rst3_n;
    logic [2:0]    req_valid3;
    logic [3*W-1:0] req_x3;
    logic [3*W-1:0] req_y3;
    logic [2:0]    req_ready3;
    logic [W-1:0]  mul_x3;
    logic [W-1:0]  mul_y3;
    logic [2*W-1:0] mul_p3;
    logic          rsp_valid3;
    logic          rsp_ready3;
    logic [2*W-1:0] rsp_p3;
    logic [IDW-1:0] rsp_id3;

    assign mul_p3 = {{W{1'b0}}, mul_x3} * {{W{1'b0}}, mul_y3};

    mul_share_arbiter #(.NREQ(3), .W(W), .IDW(IDW)) dut3 (
        .clk       (clk),
        .rst_n     (rst3_n),
        .req_valid (req_valid3),
        .req_x     (req_x3),
        .req_y     (req_y3),
        .req_ready (req_ready3),
        .mul_x     (mul_x3),
        .mul_y     (mul_y3),
        .mul_p     (mul_p3),
        .rsp_valid (rsp_valid3),
        .rsp_ready (rsp_ready3),
        .rsp_p     (rsp_p3),
        .rsp_id    (rsp_id3)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int id;
        int prod;
        int t_ready;
    } exp_t;

    exp_t            sbq[$];
    int              m_rr       = 0;
    int              last_grant = -1;
    int              last_hs    = -1;
    logic [W-1:0]    m_mx       = '0;
    logic [W-1:0]    m_my       = '0;
    logic [NREQ-1:0] gnt_mask   = '0;

    // Predictor: one operation at a time, next search starts after the last winner.
    always @(negedge clk) begin : predictor
        logic [NREQ-1:0] exp_rdy;
        int              g;
        bit              busy;
        if (!rst_n) begin
            m_rr       = 0;
            last_grant = -1;
            m_mx       = '0;
            m_my       = '0;
            gnt_mask   = '0;
            check("reset req_ready", 32'(req_ready), 32'(req_valid & 4'b0));
            check("reset mul_x", 32'(mul_x), 0);
            check("reset mul_y", 32'(mul_y), 0);
        end else begin
            check("mul_x hold", 32'(mul_x), 32'(m_mx));
            check("mul_y hold", 32'(mul_y), 32'(m_my));
            busy    = (last_grant >= 0) && !(last_hs > last_grant && cyc > last_hs);
            exp_rdy = '0;
            g       = -1;
            if (!busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(m_rr + k) % NREQ]) begin
                        g = (m_rr + k) % NREQ;
                    end
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            gnt_mask = exp_rdy;
            if (g >= 0) begin
                m_mx = req_x[g*W +: W];
                m_my = req_y[g*W +: W];
                sbq.push_back('{g, int'(m_mx) * int'(m_my), cyc + 2});
                m_rr       = (g + 1) % NREQ;
                last_grant = cyc;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the head of the queue.
    always @(negedge clk) begin : monitor
        if (!rst_n) begin
            check("reset rsp_valid", 32'(rsp_valid), 0);
            check("reset rsp_p", 32'(rsp_p), 0);
            check("reset rsp_id", 32'(rsp_id), 0);
            sbq.delete();
        end else if (sbq.size() > 0 && cyc >= sbq[0].t_ready) begin
            check("rsp_valid", 32'(rsp_valid), 1);
            check("rsp_p", 32'(rsp_p), 32'(sbq[0].prod));
            check("rsp_id", 32'(rsp_id), 32'(sbq[0].id));
            if (rsp_ready) begin
                void'(sbq.pop_front());
                last_hs = cyc;
            end
        end else begin
            check("rsp_valid quiet", 32'(rsp_valid), 0);
        end
    end

    // ---------------- stimulus driver ----------------
    logic [NREQ-1:0] pend_v = '0;
    logic [NREQ-1:0] sticky = '0;
    logic [W-1:0]    pend_x[NREQ];
    logic [W-1:0]    pend_y[NREQ];

    task automatic post(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        pend_v[i] = 1'b1;
        pend_x[i] = x;
        pend_y[i] = y;
    endtask

    // Drive the pending requests for one cycle, then retire the ones granted.
    task automatic step();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]     = pend_v[i];
            req_x[i*W +: W]  = pend_x[i];
            req_y[i*W +: W]  = pend_y[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_mask[i] && !sticky[i]) pend_v[i] = 1'b0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        pend_v = '0;
        sticky = '0;
        rst_n  = 1'b0;
        step();
        rst_n  = 1'b1;
    endtask

    // ---------------- NREQ=3 wrap-around sequence ----------------
    int g3_obs[$];
    int r3_id[$];
    int r3_p[$];
    bit done3 = 1'b0;

    always @(negedge clk) begin
        if (rst3_n) begin
            for (int i = 0; i < 3; i++) begin
                if (req_ready3[i] && req_valid3[i]) g3_obs.push_back(i);
            end
            if (rsp_valid3 && rsp_ready3) begin
                r3_id.push_back(int'(rsp_id3));
                r3_p.push_back(int'(rsp_p3));
            end
        end
    end

    initial begin : nreq3_seq
        int exp_g[3];
        int exp_p[3];
        exp_g      = '{2, 0, 2};
        exp_p      = '{63, 44, 63};
        rst3_n     = 1'b0;
        rsp_ready3 = 1'b1;
        req_valid3 = 3'b000;
        req_x3     = {4'd7, 4'd0, 4'd4};
        req_y3     = {4'd9, 4'd0, 4'd11};
        repeat (2) @(posedge clk);
        #1;
        rst3_n     = 1'b1;
        req_valid3 = 3'b100;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (g3_obs.size() >= 3) req_valid3 = 3'b000;
            else if (g3_obs.size() >= 1) req_valid3 = 3'b101;
        end
        check("nreq3 grant count", 32'(g3_obs.size()), 3);
        check("nreq3 rsp count", 32'(r3_p.size()), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < g3_obs.size()) check("nreq3 grant order", 32'(g3_obs[k]), 32'(exp_g[k]));
            if (k < r3_p.size()) begin
                check("nreq3 rsp_id", 32'(r3_id[k]), 32'(exp_g[k]));
                check("nreq3 rsp_p", 32'(r3_p[k]), 32'(exp_p[k]));
            end
        end
        done3 = 1'b1;
    end

    // ---------------- main sequence ----------------
    initial begin : main_seq
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend_x[i] = '0;
            pend_y[i] = '0;
        end
        steps(2);
        rst_n = 1'b1;

        // single request
        rsp_ready = 1'b1;
        post(0, 4'd3, 4'd2);
        steps(5);

        // all four at once
        post(0, 4'd1, 4'd1);
        post(1, 4'd5, 4'd3);
        post(2, 4'd6, 4'd4);
        post(3, 4'd10, 4'd5);
        steps(14);

        // req0 and req2 held continuously
        sticky = 4'b0101;
        post(0, 4'd7, 4'd3);
        post(2, 4'd2, 4'd13);
        steps(12);
        sticky = '0;
        pend_v = '0;
        steps(5);

        // backpressure with the largest operands; others request meanwhile
        rsp_ready = 1'b0;
        post(0, 4'd15, 4'd15);
        step();
        post(1, 4'd2, 4'd3);
        post(3, 4'd4, 4'd4);
        steps(6);
        rsp_ready = 1'b1;
        steps(10);

        // reset while a response is pending
        rsp_ready = 1'b0;
        post(2, 4'd9, 4'd9);
        steps(4);
        do_reset();
        rsp_ready = 1'b1;
        post(1, 4'd3, 4'd5);
        post(0, 4'd11, 4'd12);
        steps(10);

        // random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i] && $urandom_range(0, 3) == 0) begin
                    post(i, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
                end else if (pend_v[i] && $urandom_range(0, 31) == 0) begin
                    pend_v[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end

        // drain
        pend_v    = '0;
        rsp_ready = 1'b1;
        steps(10);
        check("drain scoreboard empty", 32'(sbq.size()), 0);

        for (int c = 0; c < 1000 && !done3; c++) @(posedge clk);
        check("nreq3 sequence finished", 32'(done3), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
